// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory between the core port and the
// loader port. One transaction at a time, stretched over LAT memory cycles, ready pulsed once.
module mem_arbiter #(
    parameter int unsigned W   = 32,
    parameter int unsigned AW  = 32,
    parameter int unsigned LAT = 1
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [W-1:0]  cpu_wd,
    output logic          cpu_ready,

    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [W-1:0]  ldr_wd,
    output logic          ldr_ready,

    output logic [W-1:0]  rdata,
    output logic          gnt_cpu,
    output logic          gnt_ldr,
    output logic          busy,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [W-1:0]  mem_wd,
    input  logic [W-1:0]  mem_rd
);

    localparam int unsigned   CW      = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CntInit = CW'(LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_ldr_q, last_ldr_d;
    logic          gnt_cpu_q, gnt_cpu_d;
    logic          gnt_ldr_q, gnt_ldr_d;
    logic [W-1:0]  rdata_q, rdata_d;

    logic          pick_ldr;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [W-1:0]  sel_wd;

    // On a tie the port that did not win last time gets the memory.
    assign pick_ldr = ldr_req && (!cpu_req || !last_ldr_q);

    assign sel_we   = gnt_ldr_q ? ldr_we   : cpu_we;
    assign sel_addr = gnt_ldr_q ? ldr_addr : cpu_addr;
    assign sel_wd   = gnt_ldr_q ? ldr_wd   : cpu_wd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_req || ldr_req) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        last_ldr_d = last_ldr_q;
        gnt_cpu_d  = gnt_cpu_q;
        gnt_ldr_d  = gnt_ldr_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_req || ldr_req) begin
                    gnt_ldr_d = pick_ldr;
                    gnt_cpu_d = !pick_ldr;
                    cnt_d     = CntInit;
                end
            end
            StAccess: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    if (!sel_we) begin
                        rdata_d = mem_rd;
                    end
                    last_ldr_d = gnt_ldr_q;
                end
            end
            StDone: begin
                gnt_cpu_d = 1'b0;
                gnt_ldr_d = 1'b0;
            end
            default: begin
                gnt_cpu_d = 1'b0;
                gnt_ldr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            last_ldr_q <= 1'b1;
            gnt_cpu_q  <= 1'b0;
            gnt_ldr_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            last_ldr_q <= last_ldr_d;
            gnt_cpu_q  <= gnt_cpu_d;
            gnt_ldr_q  <= gnt_ldr_d;
            rdata_q    <= rdata_d;
        end
    end

    // The counter starts at LAT-1, so the first ACCESS cycle is the one still holding CntInit.
    always_comb begin
        busy      = (state_q != StIdle);
        cpu_ready = (state_q == StDone) && gnt_cpu_q;
        ldr_ready = (state_q == StDone) && gnt_ldr_q;
        gnt_cpu   = gnt_cpu_q;
        gnt_ldr   = gnt_ldr_q;
        rdata     = rdata_q;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wd    = '0;
        if (state_q == StAccess) begin
            mem_we   = sel_we && (cnt_q == CntInit);
            mem_addr = sel_addr;
            mem_wd   = sel_wd;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset)
        !(gnt_cpu_q && gnt_ldr_q));

    a_we_in_access: assert property (@(posedge clk) disable iff (reset)
        mem_we |-> (state_q == StAccess));

endmodule

// File: tb/tb_mem_arbiter.sv
// Random two-port traffic against LAT=1 and LAT=3 arbiters, each checked every cycle against a
// transaction-level model tracking the owner and its age since the grant edge.
module tb_mem_arbiter;

    localparam int unsigned W      = 32;
    localparam int unsigned AW     = 32;
    localparam int          Cycles = 3000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input int lat, input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL LAT%0d %s: got %0h want %0h", lat, tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : 3;

        logic          req  [2];
        logic          we   [2];
        logic [AW-1:0] addr [2];
        logic [W-1:0]  wd   [2];

        logic          cpu_ready, ldr_ready, gnt_cpu, gnt_ldr, busy, mem_we;
        logic [W-1:0]  rdata, mem_wd, mem_rd;
        logic [AW-1:0] mem_addr;

        logic [W-1:0]  mem     [16];
        logic [W-1:0]  ref_mem [16];

        // Model: cur 0=none 1=cpu 2=ldr; age counts edges since the grant edge.
        int            n = 0, start = 0, cur = 0, last = 2;
        bit            started = 0, armed = 0;
        logic          t_we;
        logic [AW-1:0] t_addr;
        logic [W-1:0]  t_wd;
        logic [W-1:0]  m_rdata = '0;

        mem_arbiter #(.W(W), .AW(AW), .LAT(L)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .cpu_req  (req[0]),
            .cpu_we   (we[0]),
            .cpu_addr (addr[0]),
            .cpu_wd   (wd[0]),
            .cpu_ready(cpu_ready),
            .ldr_req  (req[1]),
            .ldr_we   (we[1]),
            .ldr_addr (addr[1]),
            .ldr_wd   (wd[1]),
            .ldr_ready(ldr_ready),
            .rdata    (rdata),
            .gnt_cpu  (gnt_cpu),
            .gnt_ldr  (gnt_ldr),
            .busy     (busy),
            .mem_we   (mem_we),
            .mem_addr (mem_addr),
            .mem_wd   (mem_wd),
            .mem_rd   (mem_rd)
        );

        assign mem_rd = mem[mem_addr[3:0]];

        always @(posedge clk) begin
            if (!started) begin
                for (int i = 0; i < 16; i++) begin
                    ref_mem[i] = $urandom;
                    mem[i] <= ref_mem[i];
                end
                started = 1;
            end else if (mem_we === 1'b1) begin
                mem[mem_addr[3:0]] <= mem_wd;
            end

            n++;
            if (reset) begin
                cur     = 0;
                last    = 2;
                m_rdata = '0;
            end else if (cur == 0) begin
                if (req[0] || req[1]) begin
                    cur    = (req[0] && (!req[1] || last == 2)) ? 1 : 2;
                    start  = n;
                    t_we   = we[cur-1];
                    t_addr = addr[cur-1];
                    t_wd   = wd[cur-1];
                    if (t_we) ref_mem[t_addr[3:0]] = t_wd;
                end
            end else if (n - start == L) begin
                if (!t_we) m_rdata = ref_mem[t_addr[3:0]];
            end else if (n - start == L + 1) begin
                last = cur;
                cur  = 0;
            end
        end

        always @(negedge clk) begin
            automatic int age = n - start;
            automatic bit acc = (cur != 0) && (age < L);
            if (started) begin
                check_eq(L, "busy",      busy,      cur != 0);
                check_eq(L, "gnt_cpu",   gnt_cpu,   cur == 1);
                check_eq(L, "gnt_ldr",   gnt_ldr,   cur == 2);
                check_eq(L, "cpu_ready", cpu_ready, (cur == 1) && (age == L));
                check_eq(L, "ldr_ready", ldr_ready, (cur == 2) && (age == L));
                check_eq(L, "mem_we",    mem_we,    acc && (age == 0) && t_we);
                check_eq(L, "mem_addr",  mem_addr,  acc ? t_addr : '0);
                check_eq(L, "mem_wd",    mem_wd,    acc ? t_wd : '0);
                check_eq(L, "rdata",     rdata,     m_rdata);
            end

            // Requester agents: hold while waiting, may re-request after ready, rarely drop early.
            for (int p = 0; p < 2; p++) begin
                automatic bit mine = (cur == p + 1);
                if (!armed || (mine && age == L && $urandom_range(0, 1) == 1) ||
                    (!mine && !req[p] && $urandom_range(0, 2) == 0)) begin
                    req[p]  = 1'b1;
                    we[p]   = 1'($urandom_range(0, 1));
                    addr[p] = $urandom;
                    wd[p]   = $urandom;
                end else if (mine && age == L) begin
                    req[p] = 1'b0;
                end else if (mine && req[p] && $urandom_range(0, 29) == 0) begin
                    req[p] = 1'b0;
                end
            end
            armed = 1;
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < Cycles; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
